// File: rtl/deser_aligner.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// A HUNT/VERIFY/LOCKED tracker moves the word boundary onto received commas.
module deser_aligner #(
   parameter int               WIDTH     = 10,
   parameter int               LSB_FIRST = 1,
   parameter logic [WIDTH-1:0] COMMA_P   = 10'h17C,
   parameter logic [WIDTH-1:0] COMMA_N   = 10'h283,
   parameter int               LOCK_CNT  = 3,
   parameter int               LOSS_CNT  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ip,
   input  logic             en,
   input  logic             align_en,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   output logic             aligned,
   output logic             comma_det
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
   localparam logic [3:0]     LOCK_LIM = 4'(LOCK_CNT);
   localparam logic [3:0]     LOSS_LIM = 4'(LOSS_CNT);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] window_reg, window_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] par_out_reg;
   logic             par_valid_reg;
   logic             comma_det_reg;
   logic             aligned_reg;
   logic [3:0]       good_reg, good_next, good_inc;
   logic [3:0]       bad_reg, bad_next, bad_inc;
   logic             match;
   logic             hit;
   logic             at_boundary;
   logic             realign;

   // The window always shows the last WIDTH bits; bit order decides which end the newest bit enters.
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign window_next = {ip, window_reg[WIDTH-1:1]};
      end else begin : g_msb_first
         assign window_next = {window_reg[WIDTH-2:0], ip};
      end
   endgenerate

   assign match       = (window_next == COMMA_P) || (window_next == COMMA_N);
   assign hit         = en && match;
   assign at_boundary = (cnt_reg == LAST);
   assign good_inc    = (good_reg == 4'hF) ? good_reg : good_reg + 4'd1;
   assign bad_inc     = (bad_reg == 4'hF) ? bad_reg : bad_reg + 4'd1;

   // State register; aligned follows the state being entered so it is valid one clk later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= HUNT;
         aligned_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         aligned_reg <= (state_next == LOCKED);
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (hit) begin
         case (state_reg)
            HUNT: begin
               if (align_en) begin
                  state_next = (LOCK_CNT > 1) ? VERIFY : LOCKED;
               end
            end
            VERIFY: begin
               if (at_boundary && align_en && (good_inc >= LOCK_LIM)) begin
                  state_next = LOCKED;
               end
            end
            LOCKED: begin
               if (!at_boundary && (bad_inc >= LOSS_LIM)) begin
                  state_next = HUNT;
               end
            end
            default: state_next = HUNT;
         endcase
      end
   end

   // Action logic: realignment and the good/bad comma counters.
   always_comb begin
      realign   = 1'b0;
      good_next = good_reg;
      bad_next  = bad_reg;
      if (hit) begin
         case (state_reg)
            HUNT: begin
               if (align_en) begin
                  realign = 1'b1;
               end
            end
            VERIFY: begin
               if (at_boundary) begin
                  good_next = good_inc;
               end else if (align_en) begin
                  realign = 1'b1;
               end
            end
            LOCKED: begin
               if (at_boundary) begin
                  bad_next = 4'd0;
               end else if (bad_inc >= LOSS_LIM) begin
                  bad_next = 4'd0;
               end else begin
                  bad_next = bad_inc;
               end
            end
            default: ;
         endcase
      end
      if (realign) begin
         good_next = 4'd1;
      end
      if ((state_next == LOCKED) && (state_reg != LOCKED)) begin
         bad_next = 4'd0;
      end
   end

   // Datapath. A realign on the natural boundary still yields a single par_valid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         window_reg    <= '0;
         cnt_reg       <= '0;
         par_out_reg   <= '0;
         par_valid_reg <= 1'b0;
         comma_det_reg <= 1'b0;
         good_reg      <= 4'd0;
         bad_reg       <= 4'd0;
      end else if (en) begin
         window_reg    <= window_next;
         comma_det_reg <= match;
         good_reg      <= good_next;
         bad_reg       <= bad_next;
         if (realign) begin
            cnt_reg       <= '0;
            par_out_reg   <= window_next;
            par_valid_reg <= 1'b1;
         end else begin
            cnt_reg       <= at_boundary ? '0 : cnt_reg + CW'(1);
            par_valid_reg <= at_boundary;
            if (at_boundary) begin
               par_out_reg <= window_next;
            end
         end
      end else begin
         par_valid_reg <= 1'b0;
         comma_det_reg <= 1'b0;
      end
   end

   assign par_out   = par_out_reg;
   assign par_valid = par_valid_reg;
   assign aligned   = aligned_reg;
   assign comma_det = comma_det_reg;

endmodule

// File: tb/tb_deser_aligner.sv
// Bench for deser_aligner: LSB-first and MSB-first instances share one serial stream,
// checked against a bit-history reference model, a directed timing table and hand sequences.
module tb_deser_aligner;

   localparam logic [9:0] K_P = 10'h17C;
   localparam logic [9:0] K_N = 10'h283;

   logic       clk = 1'b0;
   logic       rst, ip, en, align_en;
   logic [9:0] par_l, par_m;
   logic       pv_l, pv_m, al_l, al_m, cd_l, cd_m;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   deser_aligner #(.WIDTH(10), .LSB_FIRST(1), .COMMA_P(10'h17C), .COMMA_N(10'h283),
                   .LOCK_CNT(3), .LOSS_CNT(4)) dut_l (
      .clk(clk), .rst(rst), .ip(ip), .en(en), .align_en(align_en),
      .par_out(par_l), .par_valid(pv_l), .aligned(al_l), .comma_det(cd_l));

   // Same commas expressed in MSB-first par_out order.
   deser_aligner #(.WIDTH(10), .LSB_FIRST(0), .COMMA_P(10'h0FA), .COMMA_N(10'h305),
                   .LOCK_CNT(3), .LOSS_CNT(4)) dut_m (
      .clk(clk), .rst(rst), .ip(ip), .en(en), .align_en(align_en),
      .par_out(par_m), .par_valid(pv_m), .aligned(al_m), .comma_det(cd_m));

   function automatic logic [9:0] rev10(input logic [9:0] v);
      logic [9:0] r;
      for (int k = 0; k < 10; k++) r[k] = v[9-k];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: received-bit history, bits since last word start, lock state.
   bit         hist[$];
   int         m_state;   // 0 hunting, 1 verifying, 2 locked
   int         m_phase, m_good, m_bad;
   logic [9:0] m_par;
   logic       m_pv, m_cd, m_al;

   function automatic logic [9:0] last_ten();
      logic [9:0] w;
      w = '0;
      for (int k = 0; k < 10; k++) if (k < hist.size()) w[9-k] = hist[k];
      return w;
   endfunction

   task automatic model_step(input logic b, input logic e, input logic a, input logic r);
      logic [9:0] w;
      logic       is_comma, edge_word, do_align;
      if (r) begin
         hist.delete();
         m_state = 0; m_phase = 0; m_good = 0; m_bad = 0;
         m_par = '0; m_pv = 0; m_cd = 0; m_al = 0;
         return;
      end
      if (!e) begin
         m_pv = 0; m_cd = 0;
         return;
      end
      hist.push_front(b);
      if (hist.size() > 10) void'(hist.pop_back());
      w         = last_ten();
      is_comma  = (w == K_P) || (w == K_N);
      edge_word = (m_phase == 9);
      do_align  = 0;
      m_phase   = edge_word ? 0 : m_phase + 1;
      m_pv      = edge_word;
      if (edge_word) m_par = w;
      m_cd = is_comma;
      if (is_comma) begin
         if (m_state == 0) begin
            if (a) begin do_align = 1; m_state = 1; end
         end else if (m_state == 1) begin
            if (edge_word) begin
               if (m_good < 15) m_good++;
               if (a && m_good >= 3) begin m_state = 2; m_bad = 0; end
            end else if (a) begin
               do_align = 1;
            end
         end else begin
            if (edge_word) m_bad = 0;
            else begin
               if (m_bad < 15) m_bad++;
               if (m_bad >= 4) begin m_state = 0; m_bad = 0; end
            end
         end
      end
      if (do_align) begin
         m_phase = 0; m_par = w; m_pv = 1; m_good = 1;
      end
      m_al = (m_state == 2);
   endtask

   task automatic tick(input logic b, input logic e, input logic a, input logic r);
      ip = b; en = e; align_en = a; rst = r;
      @(posedge clk);
      model_step(b, e, a, r);
      #1;
      chk("model_pv_lsb", pv_l, m_pv);
      chk("model_cd_lsb", cd_l, m_cd);
      chk("model_al_lsb", al_l, m_al);
      chk("model_par_lsb", par_l, m_par);
      chk("model_pv_msb", pv_m, m_pv);
      chk("model_cd_msb", cd_m, m_cd);
      chk("model_al_msb", al_m, m_al);
      chk("model_par_msb", par_m, rev10(m_par));
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic send_word(input logic [9:0] word, input logic a);
      logic [9:0] w;
      w = word;
      for (int i = 0; i < 10; i++) tick(w[i], 1'b1, a, 1'b0);
   endtask

   task automatic ck_out(input string name, input logic pv, input logic al, input logic cd);
      chk({name, "_pv_lsb"}, pv_l, pv);
      chk({name, "_al_lsb"}, al_l, al);
      chk({name, "_cd_lsb"}, cd_l, cd);
      chk({name, "_pv_msb"}, pv_m, pv);
      chk({name, "_al_msb"}, al_m, al);
      chk({name, "_cd_msb"}, cd_m, cd);
   endtask

   task automatic ck_par(input string name, input logic [9:0] p);
      chk({name, "_par_lsb"}, par_l, p);
      chk({name, "_par_msb"}, par_m, rev10(p));
   endtask

   // Acquire timeline, indexed by the count of en=1 cycles since reset release.
   typedef struct {
      int         at;
      logic       pv;
      logic       chk_par;
      logic [9:0] par;
      logic       al;
      logic       cd;
   } vec_t;

   vec_t acq_tbl[8];
   bit   acq_bits[$];

   task automatic check_vec(input int n);
      foreach (acq_tbl[i]) begin
         if (acq_tbl[i].at == n) begin
            ck_out($sformatf("acq%0d", n), acq_tbl[i].pv, acq_tbl[i].al, acq_tbl[i].cd);
            if (acq_tbl[i].chk_par) ck_par($sformatf("acq%0d", n), acq_tbl[i].par);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] w;
      int         pv_seen, n;

      acq_tbl[0] = '{10, 1'b1, 1'b1, 10'h3E0, 1'b0, 1'b0};
      acq_tbl[1] = '{11, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
      acq_tbl[2] = '{13, 1'b1, 1'b1, 10'h17C, 1'b0, 1'b1};
      acq_tbl[3] = '{23, 1'b1, 1'b1, 10'h283, 1'b0, 1'b1};
      acq_tbl[4] = '{32, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
      acq_tbl[5] = '{33, 1'b1, 1'b1, 10'h17C, 1'b1, 1'b1};
      acq_tbl[6] = '{34, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0};
      acq_tbl[7] = '{43, 1'b1, 1'b1, 10'h283, 1'b1, 1'b1};

      // 3-bit offset then K28.5 alternating disparity, LSB of each word first.
      for (int i = 0; i < 3; i++) acq_bits.push_back(1'b0);
      for (int k = 0; k < 4; k++) begin
         w = (k % 2 == 0) ? K_P : K_N;
         for (int i = 0; i < 10; i++) acq_bits.push_back(w[i]);
      end

      // Reset state
      do_reset();
      ck_out("reset", 1'b0, 1'b0, 1'b0);
      ck_par("reset", 10'h000);

      // Free run, no alignment
      w = 10'h155;
      pv_seen = 0;
      for (int t = 1; t <= 30; t++) begin
         tick(w[(t-1)%10], 1'b1, 1'b0, 1'b0);
         chk("free_pv", pv_l, (t % 10 == 0));
         if (pv_l) begin
            pv_seen++;
            ck_par("free", 10'h155);
         end
      end
      chk("free_pv_count", pv_seen, 3);
      chk("free_aligned", al_l, 1'b0);

      // Acquire
      do_reset();
      for (int t = 1; t <= 43; t++) begin
         tick(acq_bits[t-1], 1'b1, 1'b1, 1'b0);
         check_vec(t);
      end

      // Loss: one slipped bit makes every following comma off-boundary
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         send_word((k % 2 == 1) ? K_P : K_N, 1'b1);
         chk($sformatf("loss%0d_cd", k), cd_l, 1'b1);
         if (k <= 3) chk($sformatf("loss%0d_al", k), al_l, 1'b1);
         if (k == 4) ck_out("loss4", 1'b0, 1'b0, 1'b1);
         if (k == 5) begin
            ck_out("reacq", 1'b1, 1'b0, 1'b1);
            ck_par("reacq", K_P);
         end
      end

      // Gapped acquire: en alternates, timeline counts en=1 cycles only
      do_reset();
      n = 0;
      foreach (acq_bits[i]) begin
         tick(acq_bits[i], 1'b1, 1'b1, 1'b0);
         n++;
         check_vec(n);
         tick(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
         chk("gap_pv", pv_l, 1'b0);
         chk("gap_cd", cd_l, 1'b0);
      end
      chk("gap_aligned", al_l, 1'b1);

      // Reset mid-word while locked
      do_reset();
      foreach (acq_bits[i]) tick(acq_bits[i], 1'b1, 1'b1, 1'b0);
      chk("pre_rst_aligned", al_l, 1'b1);
      w = K_P;
      for (int i = 0; i < 5; i++) tick(w[i], 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      ck_out("midrst", 1'b0, 1'b0, 1'b0);
      ck_par("midrst", 10'h000);
      for (int i = 0; i < 9; i++) begin
         tick((i < 5) ? w[i+5] : 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
         chk("post_rst_pv", pv_l, 1'b0);
      end

      // Random traffic against the reference model
      do_reset();
      for (int wd = 0; wd < 300; wd++) begin
         int         kind;
         logic       a;
         logic [9:0] rw;
         kind = $urandom_range(0, 9);
         a    = ($urandom_range(0, 9) != 0);
         if (kind < 5) rw = $urandom_range(0, 1) ? K_P : K_N;
         else          rw = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 299) == 0) tick(1'b0, 1'b1, a, 1'b1);
         if (kind >= 8) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
               tick(1'($urandom_range(0, 1)), 1'b1, a, 1'b0);
         end else begin
            for (int i = 0; i < 10; i++) begin
               if ($urandom_range(0, 4) == 0) tick(1'($urandom_range(0, 1)), 1'b0, a, 1'b0);
               tick(rw[i], 1'b1, a, 1'b0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
